// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch queue slice.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  // Queue entry layout for the default 32-bit address/instruction configuration.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_entry_queue.sv
// Slot-reserving FIFO: entries are reserved with a PC at request time and
// filled with the instruction later, in order, through a separate fill pointer.
module fetch_entry_queue
  import fetch_pkg::*;
#(
  parameter int AddrSize = 32,
  parameter int DataSize = 32,
  parameter int QDepth   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   reserve,
  input  logic [AddrSize-1:0]    reserve_pc,
  input  logic                   fill,
  input  logic [DataSize-1:0]    fill_instr,
  input  logic                   dequeue,
  output logic [AddrSize-1:0]    head_pc,
  output logic [DataSize-1:0]    head_instr,
  output logic                   head_filled,
  output logic [ptr_w(QDepth):0] occupancy
);

  localparam int PW = ptr_w(QDepth);

  logic [AddrSize-1:0] pc_mem    [QDepth];
  logic [DataSize-1:0] instr_mem [QDepth];
  logic [QDepth-1:0]   filled;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW-1:0]       fill_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head      <= '0;
      tail      <= '0;
      fill_ptr  <= '0;
      occupancy <= '0;
    end else begin
      if (reserve) tail     <= tail + PW'(1);
      if (fill)    fill_ptr <= fill_ptr + PW'(1);
      if (dequeue) head     <= head + PW'(1);
      occupancy <= occupancy + (PW+1)'(reserve) - (PW+1)'(dequeue);
    end
  end

  // A stale filled bit left by a flush is cleared when its slot is reserved again.
  always_ff @(posedge clk) begin
    if (reset) begin
      filled <= '0;
    end else if (!flush) begin
      if (reserve) filled[tail]     <= 1'b0;
      if (fill)    filled[fill_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reserve) pc_mem[tail]        <= reserve_pc;
    if (fill)    instr_mem[fill_ptr] <= fill_instr;
  end

  assign head_pc     = pc_mem[head];
  assign head_instr  = instr_mem[head];
  assign head_filled = filled[head];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests and
// queues {pc, instr} for decode. Define FETCH_PERF_CNT_EN to add fetch/drop counters.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                  AddrSize       = 32,
  parameter int                  DataSize       = 32,
  parameter int                  QDepth         = 4,
  parameter int                  MaxOutstanding = 2,
  parameter logic [AddrSize-1:0] ResetVector    = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [AddrSize-1:0] redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [AddrSize-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [DataSize-1:0] imem_rsp_data,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [AddrSize-1:0] if_pc,
  output logic [DataSize-1:0] if_instr,
  output logic [AddrSize-1:0] fetch_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_dropped
`endif
);

  localparam int              PW    = ptr_w(QDepth);
  localparam int              OW    = $clog2(MaxOutstanding + 1);
  localparam logic [PW:0]     QFULL = (PW+1)'(QDepth);
  localparam logic [OW-1:0]   OMAX  = OW'(MaxOutstanding);

  logic [OW-1:0]       outstanding;
  logic [OW-1:0]       drop_cnt;
  logic [PW:0]         occupancy;
  logic [AddrSize-1:0] head_pc;
  logic [DataSize-1:0] head_instr;
  logic                head_filled;
  logic                accept;
  logic                rsp_drop;
  logic                rsp_fill;
  logic                dequeue;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign imem_req_addr  = fetch_pc;

  always_comb begin
    imem_req_valid = !reset && !redirect_valid && (occupancy < QFULL) &&
                     (outstanding < OMAX) && (drop_cnt == '0);
    accept   = imem_req_valid && imem_req_ready;
    rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
    rsp_fill = imem_rsp_valid && !rsp_drop && !reset;
    if_valid = (occupancy != '0) && head_filled;
    dequeue  = if_valid && if_ready && !redirect_valid && !reset;
    if_pc    = (occupancy != '0) ? head_pc : '0;
    if_instr = (occupancy != '0) ? head_instr : '0;
  end

  // Requests stay blocked until every pre-redirect response has been drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= ResetVector;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[AddrSize-1:2], 2'b00};
        drop_cnt <= outstanding - OW'(imem_rsp_valid);
      end else begin
        if (accept)   fetch_pc <= fetch_pc + AddrSize'(INSTR_BYTES);
        if (rsp_drop) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  fetch_entry_queue #(
    .AddrSize (AddrSize),
    .DataSize (DataSize),
    .QDepth   (QDepth)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (redirect_valid),
    .reserve     (accept),
    .reserve_pc  (fetch_pc),
    .fill        (rsp_fill),
    .fill_instr  (imem_rsp_data),
    .dequeue     (dequeue),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .head_filled (head_filled),
    .occupancy   (occupancy)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (dequeue)  perf_fetched <= perf_fetched + 32'd1;
      if (rsp_drop) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table plus randomized traffic,
// with an in-order memory model and a {pc, instr} scoreboard.
`timescale 1ns/1ps
module tb_fetch_queue_unit;

  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, imem_req_ready, imem_rsp_valid, if_ready;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, if_valid;
  logic [31:0] imem_req_addr, if_pc, if_instr, fetch_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  fetch_queue_unit #(
    .AddrSize(32), .DataSize(32), .QDepth(4), .MaxOutstanding(MO), .ResetVector(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .fetch_pc(fetch_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, redir;
    logic [31:0] rpc;
    logic        rdy, ren, ird, chk, ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] epc, efp;
    logic        perf;
  } vec_t;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] epoch; } mem_ent_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  mem_ent_t    mem_q[$];
  int          n_vec = 0, n_err = 0;
  int          model_out = 0, n_fetch = 0, n_drop = 0;
  logic [31:0] epoch = 0;
  logic        rsp_en = 1'b0, pend = 1'b0;
  logic [31:0] paddr = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mkr();
    vec_t v;
    v = '{rst:1'b1, redir:1'b0, rpc:32'h0, rdy:1'b1, ren:1'b0, ird:1'b1, chk:1'b0,
          ev:1'b0, ea:32'h0, eiv:1'b0, epc:32'h0, efp:32'h0, perf:1'b0};
    return v;
  endfunction

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic ren,
                              input logic ird, input logic ev, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] epc, input logic [31:0] efp);
    vec_t v;
    v = '{rst:1'b0, redir:redir, rpc:rpc, rdy:1'b1, ren:ren, ird:ird, chk:1'b1,
          ev:ev, ea:ea, eiv:eiv, epc:epc, efp:efp, perf:1'b0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'(n_fetch));
    check("perf_dropped", perf_dropped, 32'(n_drop));
`endif
  endtask

  // Drive the memory response for this cycle, then sample and update the models.
  task automatic sample();
    mem_ent_t f;
    exp_t     e;
    logic     acc, rsp, deq;
    imem_rsp_valid = rsp_en && !reset && (mem_q.size() != 0);
    imem_rsp_data  = (mem_q.size() != 0) ? instr_of(mem_q[0].addr) : 32'h0;
    @(negedge clk);
    acc = (imem_req_valid === 1'b1) && imem_req_ready && !reset;
    rsp = imem_rsp_valid;
    deq = (if_valid === 1'b1) && if_ready && !redirect_valid && !reset;
    if (!reset && model_out == MO) check("req_at_max_outstanding", 32'(imem_req_valid), 32'd0);
    if (!reset && pend && !redirect_valid) begin
      check("req_hold_valid", 32'(imem_req_valid), 32'd1);
      check("req_hold_addr", imem_req_addr, paddr);
    end
    if (rsp) check("rsp_has_outstanding", 32'(model_out > 0), 32'd1);
    if (deq) begin
      n_fetch++;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_underflow: got if_pc %h, expected no dequeue", if_pc);
      end else begin
        e = sb.pop_front();
        check("sb_if_pc", if_pc, e.pc);
        check("sb_if_instr", if_instr, e.instr);
      end
    end
    if (rsp) begin
      f = mem_q.pop_front();
      if (f.epoch != epoch || redirect_valid) n_drop++;
    end
    if (acc) begin
      mem_q.push_back('{addr: imem_req_addr, epoch: epoch});
      sb.push_back('{pc: imem_req_addr, instr: instr_of(imem_req_addr)});
    end
    if (redirect_valid && !reset) begin
      sb.delete();
      epoch++;
    end
    pend  = (imem_req_valid === 1'b1) && !imem_req_ready && !reset;
    paddr = imem_req_addr;
    if (reset) begin
      sb.delete(); mem_q.delete();
      model_out = 0; n_fetch = 0; n_drop = 0;
    end else begin
      model_out = model_out + int'(acc) - int'(rsp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset state
    advance();
    sample(); advance();
    sample();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    advance();
    check_perf();

    // Streaming with 1-cycle memory and decode always ready
    vecs.push_back(mkr());
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h00, 0, 0,      32'h00));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h04, 0, 0,      32'h04));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h08, 1, 32'h00, 32'h08));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h0C, 1, 32'h04, 32'h0C));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h10, 1, 32'h08, 32'h10));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h14, 1, 32'h0C, 32'h14));
    // Decode stalled: fill to 4 entries, hold head, then drain
    vecs.push_back(mkr());
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h00, 0, 0,      32'h00));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h04, 0, 0,      32'h04));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h08, 1, 32'h00, 32'h08));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h0C, 1, 32'h00, 32'h0C));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h00, 1, 32'h00, 32'h10));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h00, 1, 32'h00, 32'h10));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h00, 1, 32'h00, 32'h10));
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h00, 1, 32'h00, 32'h10));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h10, 1, 32'h04, 32'h10));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h14, 1, 32'h08, 32'h14));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h18, 1, 32'h0C, 32'h18));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h1C, 1, 32'h10, 32'h1C));
    // Redirect with two requests in flight; both responses dropped
    vecs.push_back(mkr());
    vecs.push_back(mk(0, 0,        0, 1, 1, 32'h000, 0, 0,       32'h000));
    vecs.push_back(mk(0, 0,        0, 1, 1, 32'h004, 0, 0,       32'h004));
    vecs.push_back(mk(1, 32'h103,  0, 1, 0, 32'h000, 0, 0,       32'h008));
    vecs.push_back(mk(0, 0,        1, 1, 0, 32'h000, 0, 0,       32'h100));
    vecs.push_back(mk(0, 0,        1, 1, 0, 32'h000, 0, 0,       32'h100));
    vecs.push_back(mk(0, 0,        1, 1, 1, 32'h100, 0, 0,       32'h100));
    vecs.push_back(mk(0, 0,        1, 1, 1, 32'h104, 0, 0,       32'h104));
    vecs.push_back(mk(0, 0,        1, 1, 1, 32'h108, 1, 32'h100, 32'h108));
    vecs[vecs.size()-1].perf = 1'b1;
    // Redirect coinciding with a response and a would-be dequeue
    vecs.push_back(mkr());
    vecs.push_back(mk(0, 0,        0, 1, 1, 32'h000, 0, 0,       32'h000));
    vecs.push_back(mk(0, 0,        1, 1, 1, 32'h004, 0, 0,       32'h004));
    vecs.push_back(mk(0, 0,        0, 0, 1, 32'h008, 1, 32'h000, 32'h008));
    vecs.push_back(mk(1, 32'h300,  1, 1, 0, 32'h000, 1, 32'h000, 32'h00C));
    vecs.push_back(mk(0, 0,        1, 1, 0, 32'h000, 0, 0,       32'h300));
    vecs.push_back(mk(0, 0,        1, 1, 1, 32'h300, 0, 0,       32'h300));
    vecs.push_back(mk(0, 0,        1, 1, 1, 32'h304, 0, 0,       32'h304));
    vecs.push_back(mk(0, 0,        1, 1, 1, 32'h308, 1, 32'h300, 32'h308));
    vecs[vecs.size()-1].perf = 1'b1;
    // Fetch address wraps past the top of the address space
    vecs.push_back(mkr());
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0,         0, 0,             32'h0));
    vecs.push_back(mk(0, 0,             0, 1, 1, 32'hFFFF_FFFC, 0, 0,             32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0,             0, 1, 1, 32'h0,         0, 0,             32'h0));
    vecs.push_back(mk(0, 0,             1, 1, 0, 32'h0,         0, 0,             32'h4));
    vecs.push_back(mk(0, 0,             1, 1, 1, 32'h4,         1, 32'hFFFF_FFFC, 32'h4));
    vecs.push_back(mk(0, 0,             1, 1, 1, 32'h8,         1, 32'h0,         32'h8));
    // Reset with 3 entries queued and 2 outstanding
    vecs.push_back(mkr());
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00, 0, 0,      32'h00));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h04, 0, 0,      32'h04));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h08, 1, 32'h00, 32'h08));
    vecs.push_back(mkr());
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00, 0, 0,      32'h00));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h04, 0, 0,      32'h04));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h08, 1, 32'h00, 32'h08));

    for (int i = 0; i < vecs.size(); i++) begin
      reset          = vecs[i].rst;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      imem_req_ready = vecs[i].rdy;
      rsp_en         = vecs[i].ren;
      if_ready       = vecs[i].ird;
      sample();
      if (vecs[i].chk) begin
        check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].ev));
        if (vecs[i].ev) check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].ea);
        check($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].eiv));
        if (vecs[i].eiv) begin
          check($sformatf("v%0d_if_pc", i), if_pc, vecs[i].epc);
          check($sformatf("v%0d_if_instr", i), if_instr, instr_of(vecs[i].epc));
        end
        check($sformatf("v%0d_fetch_pc", i), fetch_pc, vecs[i].efp);
      end
      advance();
      if (vecs[i].perf) check_perf();
    end

    // Randomized back-pressure, response gaps and redirects
    reset = 1'b1; redirect_valid = 1'b0; rsp_en = 1'b0;
    sample(); advance();
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      rsp_en         = ($urandom_range(0, 2) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom();
      sample(); advance();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b0; rsp_en = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      sample(); advance();
    end
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_mem_empty", 32'(mem_q.size()), 32'd0);
    check("drain_if_valid", 32'(if_valid), 32'd0);
    check_perf();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
